// File: rtl/cpu_run_pkg.sv
// Shared encodings for the per-hart run/stall controller.
// State and halt-cause values are visible on debug ports, so they are fixed here.
package cpu_run_pkg;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [1:0] CAUSE_INIT = 2'b00;
    localparam logic [1:0] CAUSE_QUIT = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_STEP = 2'b11;

    typedef enum logic [1:0] {
        S_HALT = ST_HALT,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP
    } run_state_e;

    typedef logic [1:0] halt_cause_t;

    function automatic logic is_active(input run_state_e st);
        return (st == S_RUN) || (st == S_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_hart.sv
// Single-hart run/halt/step FSM with its step counter.
// Event priority: init window, quit, breakpoint, final step retire, start, step.
module cpu_run_ctrl_hart
    import cpu_run_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_win,
    input  logic              i_init_start,
    input  logic              i_start,
    input  logic              i_quit,
    input  logic              i_step,
    input  logic [STEP_W-1:0] i_step_cnt,
    input  logic              i_retire,
    input  logic              i_bp_hit,
    output logic              o_run,
    output halt_cause_t       o_cause,
    output logic              o_halted_pulse
);

    run_state_e        r_state;
    logic              r_run;
    halt_cause_t       r_cause;
    logic              r_pulse;
    logic [STEP_W-1:0] r_cnt;

    logic w_active;
    assign w_active = is_active(r_state);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_HALT;
            r_run   <= 1'b0;
            r_cause <= CAUSE_INIT;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (i_init_win) begin
                // Boot request is level-sampled every window cycle; the last one wins.
                r_state <= i_init_start ? S_RUN : S_HALT;
                r_run   <= i_init_start;
                r_cnt   <= '0;
            end else if (i_quit && w_active) begin
                r_state <= S_HALT;
                r_run   <= 1'b0;
                r_cause <= CAUSE_QUIT;
                r_pulse <= 1'b1;
                r_cnt   <= '0;
            end else if (i_bp_hit && w_active) begin
                r_state <= S_HALT;
                r_run   <= 1'b0;
                r_cause <= CAUSE_BP;
                r_pulse <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == S_STEP && i_retire) begin
                if (r_cnt == STEP_W'(1)) begin
                    r_state <= S_HALT;
                    r_run   <= 1'b0;
                    r_cause <= CAUSE_STEP;
                    r_pulse <= 1'b1;
                    r_cnt   <= '0;
                end else if (r_cnt > STEP_W'(1)) begin
                    r_cnt <= r_cnt - STEP_W'(1);
                end
            end else if (i_start && r_state != S_RUN) begin
                // Leaving STEP for RUN drops whatever step budget was left.
                r_state <= S_RUN;
                r_run   <= 1'b1;
                r_cnt   <= '0;
            end else if (i_step && r_state == S_HALT && i_step_cnt != '0) begin
                r_state <= S_STEP;
                r_run   <= 1'b1;
                r_cnt   <= i_step_cnt;
            end
        end
    end

    assign o_run          = r_run;
    assign o_cause        = r_cause;
    assign o_halted_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stall controller for NUM_HART harts: shared post-reset init window,
// per-hart FSMs driving each pipeline's stall input.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_HART = 2,
    parameter int INIT_DLY = 2,
    parameter int STEP_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_HART-1:0]   i_init_cpu_start,
    input  logic [NUM_HART-1:0]   i_cpu_start,
    input  logic [NUM_HART-1:0]   i_quit_cmd,
    input  logic [NUM_HART-1:0]   i_step_cmd,
    input  logic [STEP_W-1:0]     i_step_cnt,
    input  logic [NUM_HART-1:0]   i_retire,
    input  logic [NUM_HART-1:0]   i_bp_hit,
    output logic [NUM_HART-1:0]   o_cpu_run_state,
    output logic [NUM_HART-1:0]   o_stall,
    output logic [2*NUM_HART-1:0] o_halt_cause,
    output logic [NUM_HART-1:0]   o_halted_pulse
);

    localparam int INIT_W = $clog2(INIT_DLY + 1);

    logic [INIT_W-1:0] r_init_cnt;
    logic              w_init_win;

    assign w_init_win = (r_init_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init_cnt <= INIT_W'(INIT_DLY);
        end else if (w_init_win) begin
            r_init_cnt <= r_init_cnt - INIT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_HART; g++) begin : g_hart
        cpu_run_ctrl_hart #(
            .STEP_W(STEP_W)
        ) u_hart (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_init_win     (w_init_win),
            .i_init_start   (i_init_cpu_start[g]),
            .i_start        (i_cpu_start[g]),
            .i_quit         (i_quit_cmd[g]),
            .i_step         (i_step_cmd[g]),
            .i_step_cnt     (i_step_cnt),
            .i_retire       (i_retire[g]),
            .i_bp_hit       (i_bp_hit[g]),
            .o_run          (o_cpu_run_state[g]),
            .o_cause        (o_halt_cause[2*g +: 2]),
            .o_halted_pulse (o_halted_pulse[g])
        );
    end

    assign o_stall = ~o_cpu_run_state;

endmodule
